// File: rtl/bus_initiator.sv
// Single-outstanding bus master: takes one host command, runs it on the shared
// bus with decode-miss and timeout detection, and returns a one-cycle response.
module bus_initiator #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic                  CMD_WE,
  input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
  input  logic [DATA_WIDTH-1:0] CMD_WDATA,
  output logic                  RSP_VALID,
  output logic                  RSP_ERR,
  output logic [DATA_WIDTH-1:0] RSP_RDATA,
  output logic [ADDR_WIDTH-1:0] BUS_ADDR,
  output logic                  BUS_WE,
  output logic [DATA_WIDTH-1:0] BUS_WDATA,
  output logic                  BUS_STB,
  input  logic                  BUS_SEL,
  input  logic                  BUS_ACK,
  input  logic [DATA_WIDTH-1:0] BUS_RDATA
);

  localparam int unsigned   CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, RESP} state_t;

  state_t                state, next;
  logic [CW-1:0]         cnt;
  logic                  err_d;
  logic [DATA_WIDTH-1:0] rdata_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= next;
  end

  // Ack wins over timeout when both land in the same WAIT cycle.
  always_comb begin
    next = state;
    unique case (state)
      IDLE:    if (CMD_VALID) next = ADDR;
      ADDR:    next = (!BUS_SEL || BUS_ACK) ? RESP : WAIT;
      WAIT:    if (BUS_ACK || cnt == LAST) next = RESP;
      RESP:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Response contents for whichever transition into RESP happens this cycle.
  always_comb begin
    CMD_READY = (state == IDLE);
    err_d     = (state == ADDR && !BUS_SEL) || (state == WAIT && !BUS_ACK);
    rdata_d   = (!err_d && !BUS_WE) ? BUS_RDATA : '0;
  end

  // Strobe and response valid are registered from the next state so they line
  // up with ADDR/WAIT and RESP, and clear asynchronously on reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      BUS_ADDR  <= '0;
      BUS_WE    <= 1'b0;
      BUS_WDATA <= '0;
      BUS_STB   <= 1'b0;
      RSP_VALID <= 1'b0;
      RSP_ERR   <= 1'b0;
      RSP_RDATA <= '0;
      cnt       <= '0;
    end else begin
      BUS_STB   <= (next == ADDR) || (next == WAIT);
      RSP_VALID <= (next == RESP);
      if (state == IDLE && CMD_VALID) begin
        BUS_ADDR  <= CMD_ADDR;
        BUS_WE    <= CMD_WE;
        BUS_WDATA <= CMD_WDATA;
      end
      if (next == RESP) begin
        RSP_ERR   <= err_d;
        RSP_RDATA <= rdata_d;
      end
      if (state == ADDR)
        cnt <= '0;
      else if (state == WAIT && !BUS_ACK && cnt != LAST)
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: doc/bus_initiator.md
Name: bus_initiator

Overview:
- Single-outstanding bus master for the shared address bus.
- Accepts one read or write command at a time from a host-side requester.
- Drives the bus address, write data and strobe toward the slave decoders.
- Waits for the selected slave to acknowledge, then returns read data or an error. An error is either a decode miss (no slave claims the address) or a timeout.

Parameters:
- ADDR_WIDTH, 32, width of command and bus address.
- DATA_WIDTH, 32, width of read and write data.
- TIMEOUT, 15, maximum wait cycles after address phase before the transfer aborts with an error; legal range 1..255.

Ports:
- CLK  input  1  clock; all logic on rising edge.
- RST  input  1  asynchronous, active-high reset.
- CMD_VALID  input  1  host presents a command.
- CMD_READY  output  1  initiator can accept a command; equals (state==IDLE).
- CMD_WE  input  1  1 = write, 0 = read.
- CMD_ADDR  input  ADDR_WIDTH  target address.
- CMD_WDATA  input  DATA_WIDTH  write data.
- RSP_VALID  output  1  one-cycle response pulse.
- RSP_ERR  output  1  response is an error (decode miss or timeout); valid with RSP_VALID.
- RSP_RDATA  output  DATA_WIDTH  read data; valid with RSP_VALID.
- BUS_ADDR  output  ADDR_WIDTH  registered bus address.
- BUS_WE  output  1  registered write enable.
- BUS_WDATA  output  DATA_WIDTH  registered write data.
- BUS_STB  output  1  transfer strobe.
- BUS_SEL  input  1  OR of all slave decoder REQ outputs for the current BUS_ADDR.
- BUS_ACK  input  1  selected slave completes the transfer this cycle.
- BUS_RDATA  input  DATA_WIDTH  slave read data; sampled only when BUS_ACK=1.

Behaviour:
- Reset: state=IDLE. All registered outputs are 0: BUS_ADDR, BUS_WE, BUS_WDATA, BUS_STB, RSP_VALID, RSP_ERR, RSP_RDATA, wait counter. CMD_READY is 1 from the first cycle after reset.
- Reset mid-transfer: the transfer is abandoned immediately and no response is issued. BUS_STB drops asynchronously.
- States: IDLE, ADDR, WAIT, RESP.
- IDLE:
  - CMD_READY=1, BUS_STB=0.
  - On CMD_VALID=1 at a clock edge, latch CMD_ADDR, CMD_WE, CMD_WDATA into the BUS_* registers; go to ADDR.
  - Command fields are ignored when CMD_VALID=0.
- ADDR (1 cycle):
  - BUS_STB=1; sample BUS_SEL.
  - BUS_SEL=0 → RESP with ERR=1, RDATA=0.
  - BUS_SEL=1 and BUS_ACK=1 (zero-wait slave) → RESP with ERR=0, RDATA=BUS_RDATA for reads, else 0.
  - BUS_SEL=1 and BUS_ACK=0 → WAIT; counter cleared to 0.
- WAIT:
  - BUS_STB=1; BUS_ADDR, BUS_WE and BUS_WDATA are held stable.
  - Counter increments each cycle without an ack.
  - BUS_ACK=1 → RESP, ERR=0, data as in ADDR. Ack takes priority over timeout in the same cycle.
  - Counter reaches TIMEOUT-1 with BUS_ACK=0 → RESP, ERR=1, RDATA=0.
  - BUS_SEL is not re-checked in WAIT.
- RESP (1 cycle):
  - RSP_VALID=1, BUS_STB=0, CMD_READY=0.
  - Next state is IDLE. The host has no backpressure and must consume the pulse.
- RSP_ERR and RSP_RDATA are registered on entry to RESP. They hold their value until the next RESP (not cleared in IDLE).
- BUS_ACK outside ADDR/WAIT is ignored.
- Latency, command accept edge = cycle 0:
  - Zero-wait: RSP_VALID in cycle 2.
  - N wait states: RSP_VALID in cycle 2+N.
  - Decode miss: RSP_VALID in cycle 2.
  - Timeout: RSP_VALID in cycle 2+TIMEOUT.
  - Minimum command-to-command spacing is 3 cycles; next CMD_READY is in cycle 3.
- Counter width is clog2(TIMEOUT+1) bits; it never wraps.

Test Plan:
- Zero-wait read: reset, CMD addr=0x0000_0010, WE=0, BUS_SEL=1, BUS_ACK=1 in ADDR, BUS_RDATA=0xDEAD_BEEF → RSP_VALID in cycle 2, ERR=0, RDATA=0xDEAD_BEEF, BUS_STB high exactly 1 cycle.
- Write with 3 wait states: WE=1, addr=0x0000_0400, WDATA=0x1234_5678, ACK on 4th strobe cycle → BUS_WDATA/BUS_ADDR stable for 4 cycles, RSP_VALID in cycle 5, ERR=0, RDATA=0.
- Decode miss: addr=0xFFFF_FFF0, BUS_SEL=0 → RSP_VALID in cycle 2, ERR=1, BUS_STB high 1 cycle only.
- Timeout with TIMEOUT=15: BUS_SEL=1, no ACK → BUS_STB high 16 cycles, RSP_VALID in cycle 17, ERR=1. With ACK in the final wait cycle instead → ERR=0, same cycle.
- Back-to-back: CMD_VALID held high with two different read commands → second accepted in cycle 3, responses in cycles 2 and 5, no data mixing.
- Reset mid-WAIT: assert RST in wait cycle 2 → BUS_STB=0 immediately, no RSP_VALID. After release, CMD_READY=1 and a new read completes normally.
